vga_timing_rx: RTL and testbench

// Sink-side counterpart of the VGA sync generator. Samples hsync/vsync (active-low,

---
 rtl/vga_timing_rx.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: sink-side VGA timing recovery. Registers active-low hsync/vsync,
// rebuilds the generator's pixel position, measures line/frame periods and
// reports lock once a full frame matches the configured timing.
module vga_timing_rx #(
  parameter int activeHvideo = 640,
  parameter int activeVvideo = 480,
  parameter int hfp          = 24,
  parameter int hpulse       = 40,
  parameter int hbp          = 128,
  parameter int vfp          = 9,
  parameter int vpulse       = 3,
  parameter int vbp          = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  x_px,
  output logic [9:0]  y_px,
  output logic        activevideo,
  output logic        locked,
  output logic        sync_err,
  output logic [10:0] h_total,
  output logic [9:0]  v_total
);

  localparam int blackH  = hfp + hpulse + hbp;
  localparam int blackV  = vfp + vpulse + vbp;
  localparam int hpixels = blackH + activeHvideo;
  localparam int vlines  = blackV + activeVvideo;

  localparam logic [9:0]  HFP_V     = 10'(hfp);
  localparam logic [9:0]  VFP_V     = 10'(vfp);
  localparam logic [9:0]  HLAST_V   = 10'(hpixels - 1);
  localparam logic [9:0]  VLAST_V   = 10'(vlines - 1);
  localparam logic [9:0]  BLACKH_V  = 10'(blackH);
  localparam logic [9:0]  BLACKV_V  = 10'(blackV);
  localparam logic [9:0]  VLINES_V  = 10'(vlines);
  localparam logic [10:0] HPIX_V    = 11'(hpixels);
  localparam logic [10:0] HLOST_V   = 11'(2 * hpixels - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic [10:0] hcnt_q, hcnt_d, h_total_q, h_total_d;
  logic [9:0]  vcnt_q, vcnt_d, v_total_q, v_total_d;
  logic        h_seen_q, h_seen_d;
  logic        frame_ok_q, frame_ok_d;
  logic        sync_err_q, sync_err_d;

  logic        hs_edge, vs_edge, hc_wrap;
  logic [9:0]  hc_pred, vc_pred, v_meas;
  logic [10:0] h_meas;
  logic        h_bad, h_per_bad, v_bad, h_lost, ok_now;

  // Edge detection, position prediction/reload and period measurement
  always_comb begin
    hs_edge   = ~hsync & hs_q;
    vs_edge   = ~vsync & vs_q;
    hs_d      = hsync;
    vs_d      = vsync;
    hc_wrap   = (hc_q == HLAST_V);
    hc_pred   = hc_wrap ? '0 : hc_q + 10'd1;
    vc_pred   = vc_q;
    if (hc_wrap) begin
      vc_pred = (vc_q == VLAST_V) ? '0 : vc_q + 10'd1;
    end
    hc_d      = hs_edge ? HFP_V : hc_pred;
    vc_d      = vs_edge ? VFP_V : vc_pred;

    h_meas    = (hcnt_q == '1) ? hcnt_q : hcnt_q + 11'd1;
    hcnt_d    = hs_edge ? '0 : h_meas;
    h_seen_d  = h_seen_q | hs_edge;
    h_total_d = (hs_edge && h_seen_q) ? h_meas : h_total_q;

    // an hsync edge coinciding with the vsync edge is counted into the ending frame
    v_meas    = (hs_edge && vcnt_q != '1) ? vcnt_q + 10'd1 : vcnt_q;
    vcnt_d    = vs_edge ? '0 : v_meas;
    v_total_d = vs_edge ? v_meas : v_total_q;

    h_bad     = hs_edge && (hc_pred != HFP_V);
    h_per_bad = hs_edge && h_seen_q && (h_meas != HPIX_V);
    v_bad     = vs_edge && (vc_pred != VFP_V);
    h_lost    = !hs_edge && (hcnt_q == HLOST_V);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      hc_q       <= '0;
      vc_q       <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      h_total_q  <= '0;
      v_total_q  <= '0;
      h_seen_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      h_total_q  <= h_total_d;
      v_total_q  <= v_total_d;
      h_seen_q   <= h_seen_d;
      frame_ok_q <= frame_ok_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock FSM next state: qualify one full frame, then watch for violations
  always_comb begin
    state_d    = state_q;
    frame_ok_d = frame_ok_q;
    sync_err_d = 1'b0;
    ok_now     = frame_ok_q && !h_bad && !h_per_bad;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d    = CHECK;
          frame_ok_d = 1'b1;
        end
      end
      CHECK: begin
        if (vs_edge) begin
          frame_ok_d = 1'b1;
          if (ok_now && v_meas == VLINES_V) begin
            state_d = LOCKED;
          end
        end else begin
          frame_ok_d = ok_now;
        end
      end
      LOCKED: begin
        if (h_bad || v_bad || h_lost) begin
          sync_err_d = 1'b1;
          state_d    = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Outputs from state and position registers
  always_comb begin
    locked      = (state_q == LOCKED);
    activevideo = locked && (hc_q >= BLACKH_V) && (vc_q >= BLACKV_V);
    x_px        = activevideo ? hc_q - BLACKH_V : '0;
    y_px        = activevideo ? vc_q - BLACKV_V : '0;
    sync_err    = sync_err_q;
    h_total     = h_total_q;
    v_total     = v_total_q;
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives a generator-style sync stream (reduced timing so whole
// frames fit in a short run) and checks recovered position, lock and periods
// through a cycle-stamped expectation queue drained by a monitor.
module tb_vga_timing_rx;

  localparam int H_ACT = 24, H_FP = 4, H_PULSE = 4, H_BP = 8;
  localparam int V_ACT = 12, V_FP = 2, V_PULSE = 2, V_BP = 4;
  localparam int H_PIX  = H_ACT + H_FP + H_PULSE + H_BP;  // 40
  localparam int V_LINES = V_ACT + V_FP + V_PULSE + V_BP; // 20

  localparam int S_LOCK = 0, S_AV = 1, S_X = 2, S_Y = 3, S_HT = 4, S_VT = 5, S_SE = 6;

  logic        clk, rst, hsync, vsync;
  logic [9:0]  x_px, y_px, v_total;
  logic [10:0] h_total;
  logic        activevideo, locked, sync_err;

  vga_timing_rx #(
    .activeHvideo(H_ACT), .activeVvideo(V_ACT),
    .hfp(H_FP), .hpulse(H_PULSE), .hbp(H_BP),
    .vfp(V_FP), .vpulse(V_PULSE), .vbp(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .x_px(x_px), .y_px(y_px), .activevideo(activevideo), .locked(locked),
    .sync_err(sync_err), .h_total(h_total), .v_total(v_total)
  );

  typedef struct { int cyc; int sig; int val; } exp_t;
  exp_t sbq[$];

  int  cyc = 0;
  int  checks = 0, errors = 0;
  int  exp_err_cyc = -1;
  bit  no_lock = 0;

  int  gen_hc, gen_vc, gen_vlines, delay_vc;
  bit  hold_h, prev_hs, prev_vs, hs_edge_flag, vs_edge_flag;
  int  last_hs_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
    $fatal(1);
  end

  function automatic string sig_name(int s);
    case (s)
      S_LOCK: return "locked";
      S_AV:   return "activevideo";
      S_X:    return "x_px";
      S_Y:    return "y_px";
      S_HT:   return "h_total";
      S_VT:   return "v_total";
      default: return "sync_err";
    endcase
  endfunction

  function automatic int dut_val(int s);
    case (s)
      S_LOCK: return int'(locked);
      S_AV:   return int'(activevideo);
      S_X:    return int'(x_px);
      S_Y:    return int'(y_px);
      S_HT:   return int'(h_total);
      S_VT:   return int'(v_total);
      default: return int'(sync_err);
    endcase
  endfunction

  // Monitor: per-cycle sync_err/lock watch plus scoreboard drain
  always @(negedge clk) begin : monitor
    int i;
    int got;
    checks++;
    if (sync_err !== (cyc == exp_err_cyc)) begin
      errors++;
      $display("FAIL sync_err_pulse cyc %0d got %0b want %0b", cyc, sync_err, cyc == exp_err_cyc);
    end
    if (no_lock) begin
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL never_lock cyc %0d got %0b want 0", cyc, locked);
      end
    end
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].cyc == cyc) begin
        got = dut_val(sbq[i].sig);
        checks++;
        if (got != sbq[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d got %0d want %0d", sig_name(sbq[i].sig), cyc, got, sbq[i].val);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_%s cyc %0d got unchecked want %0d", sig_name(sbq[i].sig), sbq[i].cyc, sbq[i].val);
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input int c, input int s, input int v);
    sbq.push_back('{c, s, v});
  endtask

  task automatic push_all_zero(input int c);
    for (int s = S_LOCK; s <= S_SE; s++) push(c, s, 0);
  endtask

  // Drive the sync levels for the current generator position
  task automatic drive_cur();
    bit h, v;
    int hs_start;
    hs_start = (gen_vc == delay_vc) ? H_FP + 1 : H_FP;
    h = !(gen_hc >= hs_start && gen_hc < hs_start + H_PULSE);
    if (hold_h) h = 1'b1;
    v = !(gen_vc >= V_FP && gen_vc < V_FP + V_PULSE);
    hs_edge_flag = !h && prev_hs;
    vs_edge_flag = !v && prev_vs;
    if (hs_edge_flag) last_hs_s = cyc + 1;
    prev_hs = h;
    prev_vs = v;
    hsync = h;
    vsync = v;
  endtask

  // Advance the generator one pixel; the new value is sampled at edge cyc+1
  task automatic step();
    @(posedge clk);
    #1;
    gen_hc++;
    if (gen_hc == H_PIX) begin
      gen_hc = 0;
      gen_vc++;
      if (gen_vc >= gen_vlines) gen_vc = 0;
    end
    drive_cur();
  endtask

  task automatic bound_fail(input string what);
    checks++;
    errors++;
    $display("FAIL %s cyc %0d got timeout want event", what, cyc);
  endtask

  task automatic wait_vs(output int s);
    int n = 0;
    do begin step(); n++; end while (!vs_edge_flag && n < 2000);
    if (!vs_edge_flag) bound_fail("wait_vsync");
    s = cyc + 1;
  endtask

  task automatic wait_hs(input int line, output int s);
    int n = 0;
    do begin step(); n++; end while (!(hs_edge_flag && (line < 0 || gen_vc == line)) && n < 2000);
    if (!hs_edge_flag) bound_fail("wait_hsync");
    s = cyc + 1;
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    do begin step(); n++; end while (!(gen_hc == h && (v < 0 || gen_vc == v)) && n < 2000);
    if (gen_hc != h) bound_fail("wait_pos");
  endtask

  initial begin : stim
    int s;
    rst = 1'b1;
    gen_hc = 0; gen_vc = 0; gen_vlines = V_LINES; delay_vc = -1; hold_h = 0;
    prev_hs = 1; prev_vs = 1; last_hs_s = 0;
    drive_cur();
    repeat (2) begin @(posedge clk); #1; end
    push_all_zero(cyc);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: clean stream from reset, lock right after the second vsync edge
    wait_vs(s);
    push(s, S_LOCK, 0);
    wait_vs(s);
    push(s - 1, S_LOCK, 0);
    push(s, S_LOCK, 1);
    push(s, S_HT, H_PIX);
    push(s, S_VT, V_LINES);

    // 2: active window corners
    wait_pos(15, 8);
    push(cyc + 1, S_AV, 0);
    push(cyc + 1, S_X, 0);
    step();
    push(cyc + 1, S_X, 0);
    push(cyc + 1, S_Y, 0);
    push(cyc + 1, S_AV, 1);
    wait_pos(H_PIX - 1, V_LINES - 1);
    push(cyc + 1, S_X, H_ACT - 1);
    push(cyc + 1, S_Y, V_ACT - 1);
    push(cyc + 1, S_AV, 1);
    step();
    push(cyc + 1, S_AV, 0);

    // 3: one hsync edge late by a clock
    wait_pos(0, 10);
    delay_vc = 10;
    wait_hs(10, s);
    delay_vc = -1;
    exp_err_cyc = s;
    push(s - 1, S_LOCK, 1);
    push(s, S_LOCK, 0);
    wait_vs(s);
    push(s, S_LOCK, 0);
    wait_vs(s);
    push(s - 1, S_LOCK, 0);
    push(s, S_LOCK, 1);

    // 4: hsync stuck high after the edge on line 10
    wait_hs(10, s);
    hold_h = 1;
    exp_err_cyc = s + 2 * H_PIX;
    push(s + 12, S_AV, 1);
    push(s + 12, S_X, 0);
    push(s + 12, S_Y, 2);
    push(s + 2 * H_PIX - 1, S_LOCK, 1);
    push(s + 2 * H_PIX, S_LOCK, 0);
    push(s + 2 * H_PIX, S_AV, 0);
    push(s + 2 * H_PIX + 12, S_AV, 0);
    push(s + 2 * H_PIX + 12, S_X, 0);
    repeat (2 * H_PIX + 16) step();
    hold_h = 0;
    wait_vs(s);
    wait_vs(s);
    push(s - 1, S_LOCK, 0);
    push(s, S_LOCK, 1);

    // 6: reset in the middle of an active line, then relock
    wait_pos(19, 12);
    push(cyc + 1, S_AV, 1);
    push(cyc + 1, S_X, 3);
    push(cyc + 1, S_Y, 4);
    step();
    rst = 1'b1;
    push_all_zero(cyc + 1);
    repeat (2) step();
    rst = 1'b0;
    wait_hs(-1, s);
    push(s, S_HT, 0);
    wait_hs(-1, s);
    push(s, S_HT, H_PIX);
    wait_vs(s);
    push(s, S_LOCK, 0);
    wait_vs(s);
    push(s - 1, S_LOCK, 0);
    push(s, S_LOCK, 1);
    push(s, S_VT, V_LINES);

    // 5: one extra line per frame never locks
    wait_pos(20, -1);
    rst = 1'b1;
    gen_vlines = V_LINES + 1;
    repeat (2) step();
    rst = 1'b0;
    no_lock = 1;
    for (int k = 1; k <= 4; k++) begin
      wait_vs(s);
      if (k >= 2) push(s, S_VT, V_LINES + 1);
      if (k == 4) push(s, S_HT, H_PIX);
    end
    repeat (10) step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain cyc %0d got %0d want 0", cyc, sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
